// File: rtl/rf_pkg.sv
// Shared constants and types for the write-back register file.
// Optional write-through bypass is controlled by macro RF_WB_BYPASS_EN.
package rf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One decode read port: forces $zero to 0 and, when RF_WB_BYPASS_EN is defined,
// forwards the in-flight write-back data on an address match.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic addr_is_zero_s;
  assign addr_is_zero_s = (rd_addr == {ADDR_W{1'b0}});

`ifdef RF_WB_BYPASS_EN
  logic bypass_hit_s;
  assign bypass_hit_s = wr_en && (wr_addr != {ADDR_W{1'b0}}) && (wr_addr == rd_addr);

  always_comb begin
    rd_data = stored_data;
    if (addr_is_zero_s) begin
      rd_data = {DATA_W{1'b0}};
    end else if (bypass_hit_s) begin
      rd_data = wr_data;
    end else begin
      rd_data = stored_data;
    end
  end
`else
  // Write-side inputs are intentionally ignored in the stall-based build.
  logic unused_wr_s;
  assign unused_wr_s = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rd_data = stored_data;
    if (addr_is_zero_s) begin
      rd_data = {DATA_W{1'b0}};
    end else begin
      rd_data = stored_data;
    end
  end
`endif

endmodule : rf_read_port

// File: rtl/register_file_wb.sv
// MIPS 32x32 register file fed by write-back: two decode read ports, a debug port
// and a committed-write counter. Optional bypass: macro RF_WB_BYPASS_EN.
module register_file_wb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DebugAddr,
  output logic [DATA_W-1:0] DebugData,
  output logic [31:0]       WriteCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [31:0]       count_q;
  logic [31:0]       count_d;
  logic              wr_commit_s;

  assign wr_commit_s = RegWrite && (WriteAddr != {ADDR_W{1'b0}});

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wr_commit_s) begin
      regs_d[WriteAddr] = WriteData;
      count_d           = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Reset dominates any write presented in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs_q  <= '{default: '0};
      count_q <= 32'd0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
    .rd_addr     (ReadAddr1),
    .stored_data (regs_q[ReadAddr1]),
    .wr_en       (RegWrite),
    .wr_addr     (WriteAddr),
    .wr_data     (WriteData),
    .rd_data     (ReadData1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
    .rd_addr     (ReadAddr2),
    .stored_data (regs_q[ReadAddr2]),
    .wr_en       (RegWrite),
    .wr_addr     (WriteAddr),
    .wr_data     (WriteData),
    .rd_data     (ReadData2)
  );

  assign DebugData  = regs_q[DebugAddr];
  assign WriteCount = count_q;

endmodule : register_file_wb

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb; expected values are hand-computed and
// follow RF_WB_BYPASS_EN for the read-during-write case.
module tb_register_file_wb;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DebugAddr;
  logic [31:0] DebugData;
  logic [31:0] WriteCount;

  int checks;
  int errors;

  register_file_wb dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddr1  (ReadAddr1),
    .ReadAddr2  (ReadAddr2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .DebugAddr  (DebugAddr),
    .DebugData  (DebugData),
    .WriteCount (WriteCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle away from the edge.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  logic [31:0] rdw_exp;

  initial begin
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    RegWrite  = 1'b0;
    WriteAddr = 5'd0;
    WriteData = 32'h0;
    ReadAddr1 = 5'd0;
    ReadAddr2 = 5'd0;
    DebugAddr = 5'd0;
    tick();
    tick();
    Reset = 1'b0;
    ReadAddr1 = 5'd8;
    ReadAddr2 = 5'd31;
    DebugAddr = 5'd29;
    #1;
    check("reset_count", WriteCount, 32'd0);
    check("reset_r8", ReadData1, 32'h0);
    check("reset_r31", ReadData2, 32'h0);
    check("reset_dbg_r29", DebugData, 32'h0);

    // Test 1: write r8 then reset
    RegWrite = 1'b1; WriteAddr = 5'd8; WriteData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0; DebugAddr = 5'd8;
    #1;
    check("t1_r8_written", ReadData1, 32'hDEADBEEF);
    check("t1_count1", WriteCount, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("t1_r8_after_reset", ReadData1, 32'h0);
    check("t1_dbg_after_reset", DebugData, 32'h0);
    check("t1_count_after_reset", WriteCount, 32'd0);

    // Test 2: write to $zero is dropped
    RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'h12345678; ReadAddr1 = 5'd0;
    #1;
    check("t2_zero_no_bypass", ReadData1, 32'h0);
    tick();
    RegWrite = 1'b0; DebugAddr = 5'd0;
    #1;
    check("t2_zero_read", ReadData1, 32'h0);
    check("t2_zero_dbg", DebugData, 32'h0);
    check("t2_count", WriteCount, 32'd0);

    // Test 3: consecutive writes r5, r31
    RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hA5A5A5A5;
    tick();
    WriteAddr = 5'd31; WriteData = 32'h00400020;
    tick();
    RegWrite = 1'b0; ReadAddr1 = 5'd5; ReadAddr2 = 5'd31;
    #1;
    check("t3_r5", ReadData1, 32'hA5A5A5A5);
    check("t3_r31", ReadData2, 32'h00400020);
    check("t3_count", WriteCount, 32'd2);
    ReadAddr2 = 5'd5;
    #1;
    check("t3_same_addr_p2", ReadData2, 32'hA5A5A5A5);

    // Test 4 + 6: read-during-write on r9, with debug port watching r9
    RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h00000011;
    tick();
    WriteData = 32'h00000022; ReadAddr1 = 5'd9; ReadAddr2 = 5'd5; DebugAddr = 5'd9;
`ifdef RF_WB_BYPASS_EN
    rdw_exp = 32'h00000022;
`else
    rdw_exp = 32'h00000011;
`endif
    #1;
    check("t4_rdw_before_edge", ReadData1, rdw_exp);
    check("t4_other_port_unaffected", ReadData2, 32'hA5A5A5A5);
    check("t6_dbg_before_edge", DebugData, 32'h00000011);
    check("t4_count_before", WriteCount, 32'd3);
    tick();
    RegWrite = 1'b0;
    #1;
    check("t4_rdw_after_edge", ReadData1, 32'h00000022);
    check("t6_dbg_after_edge", DebugData, 32'h00000022);
    check("t4_count_after", WriteCount, 32'd4);

    // Test 5: reset wins over a simultaneous write
    Reset = 1'b1; RegWrite = 1'b1; WriteAddr = 5'd3; WriteData = 32'h00000077;
    tick();
    Reset = 1'b0; RegWrite = 1'b0; ReadAddr1 = 5'd3; ReadAddr2 = 5'd5; DebugAddr = 5'd31;
    #1;
    check("t5_r3", ReadData1, 32'h0);
    check("t5_r5_cleared", ReadData2, 32'h0);
    check("t5_r31_cleared", DebugData, 32'h0);
    check("t5_count", WriteCount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_file_wb
